quant_pipe: RTL



---
 rtl/quant_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/quant_pipe.sv
// Two-stage valid/ready rounding quantizer: per-lane right shift, selectable rounding, optional clip.
// Define QUANT_SAT_EN to enable saturation, out_sat flags and the sat_cnt counter; otherwise results wrap.
module quant_pipe #(
    parameter int unsigned LANES = 8,
    parameter int unsigned IN_W  = 9,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned SHIFT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_output,
    input  logic [1:0]             round_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    input  logic                   sat_clr,
    output logic [15:0]            sat_cnt
);

    localparam int unsigned Q_W   = IN_W - SHIFT;
    localparam int unsigned Y_W   = Q_W + 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [Y_W-1:0] MAX_Y = Y_W'({OUT_W{1'b1}});

    logic                            s1_valid;
    logic                            s1_en;
    logic [LANES-1:0][Y_W-1:0]       s1_y;
    logic [LANES-1:0][Y_W-1:0]       y_c;
    logic [LANES-1:0][OUT_W-1:0]     clip_d_c;
    logic [LANES-1:0]                clip_s_c;
    logic                            s1_load;
    logic                            s2_load;

    // Shifted value plus rounding increment; one spare bit so the sum never wraps.
    function automatic logic [Y_W-1:0] round_lane(input logic [IN_W-1:0] x, input logic [1:0] mode);
        logic [Q_W-1:0]   q;
        logic [SHIFT-1:0] r;
        logic [SHIFT-1:0] h;
        logic             inc;
        q = x[IN_W-1:SHIFT];
        r = x[SHIFT-1:0];
        h = SHIFT'(1) << (SHIFT - 1);
        case (mode)
            2'd0:    inc = 1'b0;
            2'd2:    inc = (r > h) | ((r == h) & q[0]);
            default: inc = (r >= h);
        endcase
        return {1'b0, q} + Y_W'(inc);
    endfunction

    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;

    always_comb begin
        y_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            y_c[i] = round_lane(in_data[i*IN_W +: IN_W], round_mode);
        end
    end

    // Stage 1: rounded sums and the per-beat enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_en    <= 1'b0;
            s1_y     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_y  <= y_c;
                s1_en <= enable_output;
            end
        end
    end

    // Clip (or wrap) each lane and apply output gating.
    always_comb begin
        clip_d_c = '0;
        clip_s_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
`ifdef QUANT_SAT_EN
            if (s1_y[i] > MAX_Y) begin
                clip_d_c[i] = '1;
                clip_s_c[i] = 1'b1;
            end else begin
                clip_d_c[i] = OUT_W'(s1_y[i]);
            end
`else
            clip_d_c[i] = OUT_W'(s1_y[i]);
`endif
        end
        if (!s1_en) begin
            clip_d_c = '0;
            clip_s_c = '0;
        end
    end

`ifdef QUANT_SAT_EN
    logic [LANES-1:0] sat_q;
    logic [CNT_W-1:0] cnt_q;
    assign out_sat = sat_q;
    assign sat_cnt = cnt_q;
`else
    logic [LANES-1:0] unused_sat_q;
    logic             unused_nosat;
    assign out_sat      = '0;
    assign sat_cnt      = '0;
    assign unused_nosat = ^{sat_clr, s1_y, unused_sat_q, MAX_Y, clip_s_c};
`endif

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef QUANT_SAT_EN
            sat_q     <= '0;
`else
            unused_sat_q <= '0;
`endif
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= clip_d_c;
`ifdef QUANT_SAT_EN
                sat_q    <= clip_s_c;
`else
                unused_sat_q <= clip_s_c;
`endif
            end
        end
    end

`ifdef QUANT_SAT_EN
    // Delivered-beats-with-saturation counter; clear wins, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (sat_clr) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && (|sat_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`endif

endmodule
